// File: rtl/mt32_slot_sequencer_if.sv
// MT-32 slot sequencer signal bundle: board strobes in,
// capture/mix/frame strobes and status out.
interface mt32_slot_sequencer_if #(
  parameter int ERR_W = 8
);
  logic             clk_inh;
  logic [2:0]       ch_id;
  logic             rev_sw;
  logic             frame_ack;
  logic             clr_status;
  logic [7:0]       cap_en;
  logic [2:0]       slot;
  logic             mix_en;
  logic             frame_load;
  logic             rev_en;
  logic             frame_valid;
  logic             locked;
  logic             mute;
  logic             overrun;
  logic             timeout;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output clk_inh, ch_id, rev_sw,
    output frame_ack, clr_status,
    input  cap_en, slot, mix_en,
    input  frame_load, rev_en,
    input  frame_valid, locked, mute,
    input  overrun, timeout, err_cnt
  );

  modport slave (
    input  clk_inh, ch_id, rev_sw,
    input  frame_ack, clr_status,
    output cap_en, slot, mix_en,
    output frame_load, rev_en,
    output frame_valid, locked, mute,
    output overrun, timeout, err_cnt
  );
endinterface

// File: rtl/mt32_slot_sequencer.sv
// MT-32 DAC slot sequencer: syncs INH/slot code, tracks
// the 8-slot frame, drives capture strobes and frame handshake.
module mt32_slot_sequencer #(
  parameter int LOCK_FRAMES = 2,
  parameter int INH_TIMEOUT = 128,
  parameter int ERR_W       = 8
) (
  input logic mclk,
  input logic rst_n,
  mt32_slot_sequencer_if.slave bus
);

  localparam int TW = $clog2(INH_TIMEOUT + 1);
  localparam int GW = 4;

  typedef enum logic [1:0] {
    SEEK,
    TRACK,
    LOCKED
  } state_e;

  state_e           state_q, state_d;
  logic [GW-1:0]    good_q, good_d;

  logic             inh_s1_q, inh_s2_q, inh_s3_q;
  logic [2:0]       ch_s1_q, ch_s2_q;
  logic             rev_s1_q, rev_s2_q;

  logic [TW-1:0]    tmo_q, tmo_d;
  logic [7:0]       cap_q, cap_d;
  logic [2:0]       slot_q, slot_d;
  logic             mix_q, mix_d;
  logic             load_q, load_d;
  logic             rev_q, rev_d;
  logic             fv_q, fv_d;
  logic             lock_q, lock_d;
  logic             mute_q, mute_d;
  logic             ovr_q, ovr_d;
  logic             tflag_q, tflag_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic             fall;
  logic             match;
  logic             restart;
  logic             tmo_hit;
  logic             seq_err;
  logic             drop;
  logic             load_ev;
  logic             mix_ev;
  logic [2:0]       expected;

  assign fall     = inh_s3_q & ~inh_s2_q;
  assign expected = slot_q + 3'd1;
  assign match    = (ch_s2_q == expected);
  assign restart  = (ch_s2_q == 3'd0);
  assign tmo_hit  = ~fall &
                    (tmo_q == TW'(INH_TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    seq_err = 1'b0;
    drop    = 1'b0;
    load_ev = 1'b0;
    mix_ev  = 1'b0;
    if (fall) begin
      unique case (state_q)
        SEEK: begin
          if (restart) begin
            state_d = TRACK;
            good_d  = '0;
          end
        end
        TRACK: begin
          if (match) begin
            if (ch_s2_q == 3'd7) begin
              good_d = good_q + 4'd1;
              if (good_d == GW'(LOCK_FRAMES))
                state_d = LOCKED;
            end
          end else begin
            seq_err = 1'b1;
            good_d  = '0;
            state_d = restart ? TRACK : SEEK;
          end
        end
        LOCKED: begin
          if (match) begin
            load_ev = (ch_s2_q == 3'd0);
            mix_ev  = (ch_s2_q == 3'd4);
          end else begin
            seq_err = 1'b1;
            drop    = 1'b1;
            good_d  = '0;
            state_d = restart ? TRACK : SEEK;
          end
        end
        default: state_d = SEEK;
      endcase
    end else if (tmo_hit) begin
      state_d = SEEK;
      drop    = 1'b1;
    end
  end

  always_comb begin
    tmo_d   = tmo_q;
    cap_d   = 8'd0;
    slot_d  = slot_q;
    mix_d   = mix_ev;
    load_d  = load_ev;
    rev_d   = rev_q;
    fv_d    = fv_q;
    ovr_d   = bus.clr_status ? 1'b0 : ovr_q;
    tflag_d = (bus.clr_status ? 1'b0 : tflag_q)
              | tmo_hit;
    err_d   = bus.clr_status ? '0 : err_q;
    lock_d  = (state_d == LOCKED);
    mute_d  = ~lock_d;

    if (fall) begin
      tmo_d  = '0;
      cap_d  = 8'd1 << ch_s2_q;
      slot_d = ch_s2_q;
    end else if (tmo_q != TW'(INH_TIMEOUT)) begin
      tmo_d = tmo_q + 1'b1;
    end

    // clr_status loses to an error arriving the same cycle
    if (seq_err && (err_d != {ERR_W{1'b1}}))
      err_d = err_d + 1'b1;

    if (drop) begin
      fv_d = 1'b0;
    end else if (load_ev) begin
      fv_d  = 1'b1;
      rev_d = rev_s2_q;
      if (fv_q && !bus.frame_ack)
        ovr_d = 1'b1;
    end else if (bus.frame_ack) begin
      fv_d = 1'b0;
    end
  end

  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      inh_s1_q <= 1'b0;
      inh_s2_q <= 1'b0;
      inh_s3_q <= 1'b0;
      ch_s1_q  <= 3'd0;
      ch_s2_q  <= 3'd0;
      rev_s1_q <= 1'b0;
      rev_s2_q <= 1'b0;
      state_q  <= SEEK;
      good_q   <= '0;
      tmo_q    <= '0;
      cap_q    <= 8'd0;
      slot_q   <= 3'd0;
      mix_q    <= 1'b0;
      load_q   <= 1'b0;
      rev_q    <= 1'b0;
      fv_q     <= 1'b0;
      lock_q   <= 1'b0;
      mute_q   <= 1'b1;
      ovr_q    <= 1'b0;
      tflag_q  <= 1'b0;
      err_q    <= '0;
    end else begin
      inh_s1_q <= bus.clk_inh;
      inh_s2_q <= inh_s1_q;
      inh_s3_q <= inh_s2_q;
      ch_s1_q  <= bus.ch_id;
      ch_s2_q  <= ch_s1_q;
      rev_s1_q <= bus.rev_sw;
      rev_s2_q <= rev_s1_q;
      state_q  <= state_d;
      good_q   <= good_d;
      tmo_q    <= tmo_d;
      cap_q    <= cap_d;
      slot_q   <= slot_d;
      mix_q    <= mix_d;
      load_q   <= load_d;
      rev_q    <= rev_d;
      fv_q     <= fv_d;
      lock_q   <= lock_d;
      mute_q   <= mute_d;
      ovr_q    <= ovr_d;
      tflag_q  <= tflag_d;
      err_q    <= err_d;
    end
  end

  assign bus.cap_en      = cap_q;
  assign bus.slot        = slot_q;
  assign bus.mix_en      = mix_q;
  assign bus.frame_load  = load_q;
  assign bus.rev_en      = rev_q;
  assign bus.frame_valid = fv_q;
  assign bus.locked      = lock_q;
  assign bus.mute        = mute_q;
  assign bus.overrun     = ovr_q;
  assign bus.timeout     = tflag_q;
  assign bus.err_cnt     = err_q;

endmodule
